// File: rtl/uart_rx_frame_ctrl_if.sv
// Signal bundle between the UART receive front end and its surroundings.
// The master side is the frame controller; the slave side is line, config and parity checker.
interface uart_rx_frame_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6
);
   logic                  rx_in;
   logic [PRESC_W-1:0]    prescale;
   logic                  par_en;
   logic                  par_err;
   logic                  sampled_bit;
   logic [DATA_WIDTH-1:0] p_data;
   logic                  par_chk_en;
   logic                  data_valid;
   logic                  strt_err;
   logic                  stop_err;

   modport master (
      input  rx_in, prescale, par_en, par_err,
      output sampled_bit, p_data, par_chk_en, data_valid, strt_err, stop_err
   );

   modport slave (
      output rx_in, prescale, par_en, par_err,
      input  sampled_bit, p_data, par_chk_en, data_valid, strt_err, stop_err
   );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive front end: start detect, 3-sample majority vote per bit, LSB-first shift,
// handshake with an external registered parity checker, and frame error/valid pulses.
module uart_rx_frame_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6
) (
   input  logic                clk,
   input  logic                rst,
   uart_rx_frame_ctrl_if.master bus
);
   localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                state_q, state_d;
   logic [PRESC_W-1:0]    edge_cnt_q, edge_cnt_d;
   logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [1:0]            samp_q, samp_d;
   logic                  sampled_bit_q, sampled_bit_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  par_chk_en_q, par_chk_en_d;
   logic                  data_valid_q, data_valid_d;
   logic                  strt_err_q, strt_err_d;
   logic                  stop_err_q, stop_err_d;
   logic                  par_err_q, par_err_d;

   logic [PRESC_W-1:0]    half;
   logic [PRESC_W-1:0]    last_cnt;
   logic                  at_wrap;
   logic                  at_vote;
   logic                  maj;

   always_comb begin
      half     = bus.prescale >> 1;
      last_cnt = bus.prescale - ONE;
      at_wrap  = (edge_cnt_q == last_cnt);
      at_vote  = (edge_cnt_q == half + ONE);
      // third sample is taken straight from the line on the vote edge
      maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & bus.rx_in) | (samp_q[1] & bus.rx_in);

      state_d       = state_q;
      edge_cnt_d    = at_wrap ? '0 : edge_cnt_q + ONE;
      bit_cnt_d     = bit_cnt_q;
      samp_d        = samp_q;
      sampled_bit_d = sampled_bit_q;
      p_data_d      = p_data_q;
      par_err_d     = par_err_q;
      par_chk_en_d  = 1'b0;
      data_valid_d  = 1'b0;
      strt_err_d    = 1'b0;
      stop_err_d    = 1'b0;

      if (edge_cnt_q == half - ONE) samp_d[0] = bus.rx_in;
      if (edge_cnt_q == half)       samp_d[1] = bus.rx_in;

      case (state_q)
         IDLE: begin
            edge_cnt_d = '0;
            if (!bus.rx_in) begin
               state_d   = START;
               par_err_d = 1'b0;
            end
         end
         START: begin
            if (at_vote) begin
               sampled_bit_d = maj;
               if (maj) begin
                  strt_err_d = 1'b1;
                  state_d    = IDLE;
                  edge_cnt_d = '0;
               end
            end else if (at_wrap) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (at_vote) begin
               sampled_bit_d = maj;
               p_data_d      = DATA_WIDTH'({maj, p_data_q} >> 1);
            end
            if (at_wrap) begin
               if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                  state_d = bus.par_en ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
         end
         PARITY: begin
            if (at_vote) begin
               sampled_bit_d = maj;
               par_chk_en_d  = 1'b1;
            end
            // checker output is registered, so it settles one clk after the enable pulse
            if (edge_cnt_q == half + PRESC_W'(3)) par_err_d = bus.par_err;
            if (at_wrap) state_d = STOP;
         end
         STOP: begin
            if (at_vote) begin
               sampled_bit_d = maj;
               stop_err_d    = ~maj;
               data_valid_d  = maj & ~(bus.par_en & par_err_q);
               // leave half a bit early so a back-to-back start edge is not missed
               state_d       = IDLE;
               edge_cnt_d    = '0;
            end
         end
         default: begin
            state_d    = IDLE;
            edge_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         edge_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         samp_q        <= '0;
         sampled_bit_q <= 1'b0;
         p_data_q      <= '0;
         par_chk_en_q  <= 1'b0;
         data_valid_q  <= 1'b0;
         strt_err_q    <= 1'b0;
         stop_err_q    <= 1'b0;
         par_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         edge_cnt_q    <= edge_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         samp_q        <= samp_d;
         sampled_bit_q <= sampled_bit_d;
         p_data_q      <= p_data_d;
         par_chk_en_q  <= par_chk_en_d;
         data_valid_q  <= data_valid_d;
         strt_err_q    <= strt_err_d;
         stop_err_q    <= stop_err_d;
         par_err_q     <= par_err_d;
      end
   end

   assign bus.sampled_bit = sampled_bit_q;
   assign bus.p_data      = p_data_q;
   assign bus.par_chk_en  = par_chk_en_q;
   assign bus.data_valid  = data_valid_q;
   assign bus.strt_err    = strt_err_q;
   assign bus.stop_err    = stop_err_q;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: serial frames driven clk by clk, an even-parity
// checker model on the par_chk_en/par_err handshake, and a negedge pulse monitor.
module tb_uart_rx_frame_ctrl;
   localparam int DW = 8;
   localparam int PW = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_rx_frame_ctrl_if #(.DATA_WIDTH(DW), .PRESC_W(PW)) u_if ();

   uart_rx_frame_ctrl #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.master)
   );

   // even-parity checker: error when data plus parity bit holds an odd number of ones
   always @(posedge clk or negedge rst) begin
      if (!rst)                 u_if.par_err <= 1'b0;
      else if (u_if.par_chk_en) u_if.par_err <= ^{u_if.p_data, u_if.sampled_bit};
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int            dv_cnt  = 0;
   int            dv_cyc  = 0;
   int            se_cnt  = 0;
   int            se_cyc  = 0;
   int            stp_cnt = 0;
   int            pc_cnt  = 0;
   int            pc_cyc  = 0;
   logic          pe_seen = 1'bx;
   logic          pc_prev = 1'b0;
   logic [DW-1:0] dv_hist[$];

   always @(negedge clk) begin
      if (u_if.data_valid) begin
         dv_cnt++;
         dv_cyc = cyc;
         dv_hist.push_back(u_if.p_data);
      end
      if (u_if.strt_err) begin
         se_cnt++;
         se_cyc = cyc;
      end
      if (u_if.stop_err) stp_cnt++;
      if (pc_prev) pe_seen = u_if.par_err;
      if (u_if.par_chk_en) begin
         pc_cnt++;
         pc_cyc = cyc;
      end
      pc_prev = u_if.par_chk_en;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic b, input int n);
      for (int i = 0; i < n; i++) begin
         u_if.rx_in = b;
         @(posedge clk);
         #1;
      end
   endtask

   // g_bit is the frame bit index (0 = start) and g_clk the line clk within it to invert
   task automatic send_frame(input logic [DW-1:0] data, input logic has_par, input logic par_bit,
                             input logic stop_bit, input int g_bit, input int g_clk);
      int p;
      int nb;
      p  = int'(u_if.prescale);
      nb = has_par ? DW + 3 : DW + 2;
      for (int i = 0; i < nb; i++) begin
         logic b;
         if (i == 0)                       b = 1'b0;
         else if (i <= DW)                 b = data[i-1];
         else if (has_par && i == DW + 1)  b = par_bit;
         else                              b = stop_bit;
         for (int k = 0; k < p; k++) begin
            u_if.rx_in = b ^ ((i == g_bit) && (k == g_clk));
            @(posedge clk);
            #1;
         end
      end
   endtask

   function automatic logic [DW-1:0] last_dv(input int back);
      logic [DW-1:0] v;
      v = 'x;
      if (dv_hist.size() > back) v = dv_hist[dv_hist.size() - 1 - back];
      return v;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c0;
      int dv0;
      int se0;
      int stp0;
      int pc0;

      rst           = 1'b0;
      u_if.rx_in    = 1'b1;
      u_if.prescale = 6'd8;
      u_if.par_en   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_p_data", 32'(u_if.p_data), 32'h0);
      check("reset_flags", 32'({u_if.sampled_bit, u_if.par_chk_en, u_if.data_valid,
                                u_if.strt_err, u_if.stop_err}), 32'h0);
      rst = 1'b1;
      hold(1'b1, 4);

      // 1: prescale 8, parity on, 0xA5 with correct even parity bit 0
      dv0 = dv_cnt; se0 = se_cnt; stp0 = stp_cnt; pc0 = pc_cnt; c0 = cyc;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1, 0);
      hold(1'b1, 8);
      check("t1_dv_count", 32'(dv_cnt - dv0), 32'd1);
      check("t1_p_data", 32'(last_dv(0)), 32'hA5);
      check("t1_dv_latency", 32'(dv_cyc - c0), 32'd87);
      check("t1_chk_count", 32'(pc_cnt - pc0), 32'd1);
      check("t1_chk_latency", 32'(pc_cyc - c0), 32'd79);
      check("t1_par_err", 32'(pe_seen), 32'd0);
      check("t1_err_pulses", 32'((se_cnt - se0) + (stp_cnt - stp0)), 32'd0);

      // 2: same frame, wrong parity bit
      dv0 = dv_cnt; stp0 = stp_cnt; pc0 = pc_cnt;
      send_frame(8'hA5, 1'b1, 1'b1, 1'b1, -1, 0);
      hold(1'b1, 8);
      check("t2_chk_count", 32'(pc_cnt - pc0), 32'd1);
      check("t2_par_err", 32'(pe_seen), 32'd1);
      check("t2_dv_count", 32'(dv_cnt - dv0), 32'd0);
      check("t2_stop_err", 32'(stp_cnt - stp0), 32'd0);

      // 3: prescale 16, 2-clk low blip then idle -> start bit rejected
      u_if.prescale = 6'd16;
      u_if.par_en   = 1'b0;
      hold(1'b1, 4);
      dv0 = dv_cnt; se0 = se_cnt; c0 = cyc;
      hold(1'b0, 2);
      hold(1'b1, 40);
      check("t3_strt_count", 32'(se_cnt - se0), 32'd1);
      check("t3_strt_latency", 32'(se_cyc - c0), 32'd11);
      check("t3_dv_count", 32'(dv_cnt - dv0), 32'd0);
      send_frame(8'h96, 1'b0, 1'b0, 1'b1, -1, 0);
      hold(1'b1, 8);
      check("t3_recover_dv", 32'(dv_cnt - dv0), 32'd1);
      check("t3_recover_data", 32'(last_dv(0)), 32'h96);

      // 4: prescale 8, no parity, stop bit low, then a clean frame
      u_if.prescale = 6'd8;
      hold(1'b1, 4);
      dv0 = dv_cnt; stp0 = stp_cnt;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1, 0);
      hold(1'b1, 40);
      check("t4_stop_err", 32'(stp_cnt - stp0), 32'd1);
      check("t4_dv_count", 32'(dv_cnt - dv0), 32'd0);
      send_frame(8'h11, 1'b0, 1'b0, 1'b1, -1, 0);
      hold(1'b1, 8);
      check("t4_next_dv", 32'(dv_cnt - dv0), 32'd1);
      check("t4_next_data", 32'(last_dv(0)), 32'h11);
      check("t4_next_stop_err", 32'(stp_cnt - stp0), 32'd1);

      // 5: prescale 32, back-to-back frames, glitch on data bit 2 at edge_cnt = h
      u_if.prescale = 6'd32;
      hold(1'b1, 4);
      dv0 = dv_cnt; stp0 = stp_cnt; se0 = se_cnt;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 3, 17);
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1, -1, 0);
      hold(1'b1, 40);
      check("t5_dv_count", 32'(dv_cnt - dv0), 32'd2);
      check("t5_first_data", 32'(last_dv(1)), 32'h3C);
      check("t5_second_data", 32'(last_dv(0)), 32'hC3);
      check("t5_err_pulses", 32'((stp_cnt - stp0) + (se_cnt - se0)), 32'd0);

      // 6: reset in the middle of data bit 3, then a full frame
      u_if.prescale = 6'd8;
      hold(1'b1, 4);
      hold(1'b0, 8);
      hold(1'b0, 8);
      hold(1'b1, 8);
      hold(1'b0, 8);
      hold(1'b1, 3);
      rst = 1'b0;
      #2;
      check("t6_rst_p_data", 32'(u_if.p_data), 32'h0);
      check("t6_rst_flags", 32'({u_if.sampled_bit, u_if.par_chk_en, u_if.data_valid,
                                 u_if.strt_err, u_if.stop_err}), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      u_if.rx_in = 1'b1;
      rst        = 1'b1;
      hold(1'b1, 4);
      dv0 = dv_cnt;
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1, 0);
      hold(1'b1, 8);
      check("t6_dv_count", 32'(dv_cnt - dv0), 32'd1);
      check("t6_p_data", 32'(last_dv(0)), 32'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
